// File: rtl/op_trace_buffer.sv
// Trace capture buffer watching the main operational unit: an armed trigger records
// one operation (regime OFF -> active -> OFF) into a FIFO drained over valid/ready.
module op_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    y,
  input  logic [2:0]    s,
  input  logic          b,
  input  logic          active,
  input  logic [1:0]    regime,
  input  logic          arm,
  input  logic          clr,
  output logic [13:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic [7:0]    drops,
  output logic          overflow,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [1:0]    regime_q;
  logic [13:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic start_ev;
  logic end_ev;
  logic capture;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign start_ev = (regime_q == 2'd0) && (regime != 2'd0);
  assign end_ev   = (regime_q != 2'd0) && (regime == 2'd0);

  // The end marker is a regime change, so CAPTURE's single rule already covers it.
  always_comb begin
    capture  = 1'b0;
    state_nx = state;
    case (state)
      S_IDLE:    if (arm) state_nx = S_ARMED;
      S_ARMED:   if (start_ev) begin
                   capture  = 1'b1;
                   state_nx = S_CAPTURE;
                 end
      S_CAPTURE: begin
                   capture = active || (regime != regime_q);
                   if (end_ev) state_nx = S_DONE;
                 end
      S_DONE:    if (arm) state_nx = S_ARMED;
      default:   state_nx = S_IDLE;
    endcase
  end

  assign full      = (level == FULL_LEVEL);
  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready && !clr;
  // When full, a concurrent pop frees the slot the push overwrites.
  assign push      = capture && !clr && (!full || pop);
  assign drop      = capture && !clr && full && !pop;
  assign busy      = (state == S_ARMED) || (state == S_CAPTURE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= {regime, b, s, y};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      regime_q <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drops    <= '0;
      overflow <= 1'b0;
    end else begin
      regime_q <= regime;
      if (clr) begin
        state    <= S_IDLE;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        drops    <= '0;
        overflow <= 1'b0;
      end else begin
        state <= state_nx;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
        if (drop) begin
          overflow <= 1'b1;
          if (drops != 8'hFF) drops <= drops + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_op_trace_buffer.sv
// Bench for op_trace_buffer: directed scenarios plus random traffic, all compared
// cycle by cycle against a queue-based model of the capture rules.
module tb_op_trace_buffer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  y;
  logic [2:0]  s;
  logic        b;
  logic        active;
  logic [1:0]  regime;
  logic        arm;
  logic        clr;
  logic        out_ready;
  logic [13:0] out_data;
  logic        out_valid;
  logic [AW:0] level;
  logic [7:0]  drops;
  logic        overflow;
  logic        busy;
  logic        done;

  op_trace_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .y(y), .s(s), .b(b), .active(active), .regime(regime),
    .arm(arm), .clr(clr), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .drops(drops), .overflow(overflow),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0 idle, 1 waiting for trigger, 2 recording, 3 finished.
  logic [13:0] mq[$];
  int          m_drops;
  bit          m_ovf;
  int          m_mode;
  int          m_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit st, en, pop, take;
    if (rst) begin
      mq.delete();
      m_drops = 0; m_ovf = 0; m_mode = 0; m_prev = 0;
    end else begin
      st   = (m_prev == 0) && (regime != 0);
      en   = (m_prev != 0) && (regime == 0);
      pop  = (mq.size() > 0) && out_ready;
      if (clr) begin
        mq.delete();
        m_drops = 0; m_ovf = 0; m_mode = 0;
      end else begin
        take = (m_mode == 1) ? st : (m_mode == 2) ? (active || (int'(regime) != m_prev)) : 1'b0;
        if (pop) void'(mq.pop_front());
        if (take) begin
          if (mq.size() < DEPTH) mq.push_back({regime, b, s, y});
          else begin
            if (m_drops < 255) m_drops++;
            m_ovf = 1;
          end
        end
        if ((m_mode == 0 || m_mode == 3) && arm) m_mode = 1;
        else if (m_mode == 1 && st)              m_mode = 2;
        else if (m_mode == 2 && en)              m_mode = 3;
      end
      m_prev = int'(regime);
    end
  endtask

  task automatic compare_all();
    check("level", 32'(level), 32'(mq.size()));
    check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    check("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
    check("done", 32'(done), 32'(m_mode == 3));
    check("drops", 32'(drops), 32'(m_drops));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (mq.size() > 0) check("out_data", 32'(out_data), 32'(mq[0]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [1:0] rg, input logic [7:0] yy, input logic [2:0] ss,
                       input logic bb, input logic act, input logic ar, input logic cl,
                       input logic rdy);
    regime = rg; y = yy; s = ss; b = bb; active = act; arm = ar; clr = cl; out_ready = rdy;
    tick();
  endtask

  logic [1:0] cur_rg;

  initial begin
    rst = 1'b1; y = '0; s = '0; b = 1'b0; active = 1'b0; regime = '0;
    arm = 1'b0; clr = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Basic capture: start word plus end marker only.
    drive(2'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("armed_busy", 32'(busy), 32'd1);
    for (int unsigned i = 0; i < 3; i++) drive(2'd3, 8'h5A, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(2'd0, 8'h5A, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("basic_level", 32'(level), 32'd2);
    check("basic_done", 32'(done), 32'd1);
    check("basic_head", 32'(out_data), 32'h305A);
    drive(2'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("basic_marker", 32'(out_data), 32'h005A);
    drive(2'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("basic_drained", 32'(level), 32'd0);

    // Active stream: 4 active samples then the marker.
    drive(2'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(2'd1, 8'h11, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("stream_valid_rise", 32'(out_valid), 32'd1);
    drive(2'd1, 8'h22, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(2'd1, 8'h33, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(2'd1, 8'h44, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(2'd0, 8'h55, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("stream_level", 32'(level), 32'd5);
    for (int unsigned i = 0; i < 5; i++) drive(2'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Overflow: 12 pushes into an 8-deep FIFO, then full with simultaneous pop.
    drive(2'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 12; i++)
      drive(2'd2, 8'(i), 3'(i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ovf_level", 32'(level), 32'd8);
    check("ovf_drops", 32'(drops), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head", 32'(out_data), 32'h2000);
    for (int unsigned i = 0; i < 5; i++)
      drive(2'd2, 8'h80 + 8'(i), 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("fullpop_level", 32'(level), 32'd8);
    check("fullpop_drops", 32'(drops), 32'd4);
    drive(2'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 10; i++) drive(2'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Not armed: clr back to idle, regime toggles capture nothing.
    drive(2'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(2'd2, 8'h77, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(2'd0, 8'h77, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_level", 32'(level), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Clear with arm mid-capture at level 5, then rearm.
    drive(2'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 5; i++) drive(2'd1, 8'hC0 + 8'(i), 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_clr_level", 32'(level), 32'd5);
    drive(2'd1, 8'hCC, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_level", 32'(level), 32'd0);
    check("clr_valid", 32'(out_valid), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    drive(2'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(2'd3, 8'hE1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rearm_head", 32'(out_data), 32'h3DE1);

    // Random traffic.
    cur_rg = 2'd3;
    for (int unsigned i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) cur_rg = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 399) == 0);
      drive(cur_rg, 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 3) != 0) && ($urandom_range(0, 1) == 0 || i % 200 < 100));
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
